// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   Execute-stage hazard controller for the in-order core. Keeps a shadow
//   copy of the EX/MEM/WB destination registers and derives:
//     - registered operand forward selects for the EX instruction
//     - the load-use stall (or full interlock when forwarding is disabled)
//     - an IDLE/BUSY sequencer that holds EX for multi-cycle operations
//
//   Build option: define HAZ_FWD_EN to enable forwarding and load-use-only
//   stalls. With HAZ_FWD_EN undefined, fwd_sel1/2 are tied to 00 and any
//   dependence on EX, MEM or WB interlocks until it retires.
//
//   Ports
//     clk, reset                     rising-edge clock, sync active-high reset
//     id_valid                       decode holds a valid instruction
//     id_rs1/id_rs2, id_rs*_used     source indices and read enables
//     id_rd, id_rd_wen               destination index and write enable
//     id_is_load                     instruction is a load
//     id_mc, id_mc_lat               multi-cycle op and its total EX cycles
//     stall                          freeze IF/ID and ID/EX (combinational)
//     ex_bubble                      ID/EX loads a NOP this edge (combinational)
//     ex_valid                       valid instruction in EX (registered)
//     fwd_sel1/fwd_sel2              00 regfile, 01 EX/MEM, 10 MEM/WB (registered)
//     busy                           sequencer in BUSY (registered)
module ex_hazard_ctrl #(
    parameter int unsigned REG_ADDR = 5,
    parameter int unsigned LAT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic                id_rd_wen,
    input  logic                id_is_load,
    input  logic                id_mc,
    input  logic [LAT_W-1:0]    id_mc_lat,
    output logic                stall,
    output logic                ex_bubble,
    output logic                ex_valid,
    output logic [1:0]          fwd_sel1,
    output logic [1:0]          fwd_sel2,
    output logic                busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LAT_W-1:0]    r_cnt;

    logic                r_ex_v;
    logic [REG_ADDR-1:0] r_ex_rd;
    logic                r_ex_wen;
    logic                r_mem_v;
    logic [REG_ADDR-1:0] r_mem_rd;
    logic                r_mem_wen;

    logic                w_m1_ex;
    logic                w_m2_ex;
    logic                w_m1_mem;
    logic                w_m2_mem;
    logic                w_haz;
    logic                w_issue;
    logic                w_mc_long;

    // Source matches a slot: read enabled, slot writes, same index, not x0.
    function automatic logic f_match(
        input logic                used,
        input logic [REG_ADDR-1:0] idx,
        input logic                v,
        input logic                wen,
        input logic [REG_ADDR-1:0] rd
    );
        return used && v && wen && (rd == idx) && (idx != '0);
    endfunction

    assign w_m1_ex  = f_match(id_rs1_used, id_rs1, r_ex_v,  r_ex_wen,  r_ex_rd);
    assign w_m2_ex  = f_match(id_rs2_used, id_rs2, r_ex_v,  r_ex_wen,  r_ex_rd);
    assign w_m1_mem = f_match(id_rs1_used, id_rs1, r_mem_v, r_mem_wen, r_mem_rd);
    assign w_m2_mem = f_match(id_rs2_used, id_rs2, r_mem_v, r_mem_wen, r_mem_rd);

`ifdef HAZ_FWD_EN
    // Only the EX slot's load flag is ever consulted, so it is not carried further.
    logic       r_ex_ld;
    logic [1:0] r_fwd1;
    logic [1:0] r_fwd2;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    assign w_haz  = id_valid && r_ex_ld && (w_m1_ex || w_m2_ex);
    // EX/MEM wins over MEM/WB; a load in EX is never a forward source.
    assign w_fwd1 = (w_m1_ex && !r_ex_ld) ? 2'b01 : (w_m1_mem ? 2'b10 : 2'b00);
    assign w_fwd2 = (w_m2_ex && !r_ex_ld) ? 2'b01 : (w_m2_mem ? 2'b10 : 2'b00);
    assign fwd_sel1 = r_fwd1;
    assign fwd_sel2 = r_fwd2;
`else
    // The WB slot only matters for the interlock, so it exists only in this build.
    logic                r_wb_v;
    logic [REG_ADDR-1:0] r_wb_rd;
    logic                r_wb_wen;
    logic                w_m1_wb;
    logic                w_m2_wb;

    assign w_m1_wb  = f_match(id_rs1_used, id_rs1, r_wb_v, r_wb_wen, r_wb_rd);
    assign w_m2_wb  = f_match(id_rs2_used, id_rs2, r_wb_v, r_wb_wen, r_wb_rd);
    assign w_haz    = id_valid && (w_m1_ex || w_m2_ex || w_m1_mem || w_m2_mem ||
                                   w_m1_wb || w_m2_wb);
    assign fwd_sel1 = 2'b00;
    assign fwd_sel2 = 2'b00;
`endif

    // Issue decision deliberately independent of stall to keep it loop-free.
    assign w_issue   = id_valid && !w_haz && (r_state == ST_IDLE);
    assign w_mc_long = w_issue && id_mc && (id_mc_lat >= LAT_W'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        ex_bubble   = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_BUSY: begin
                    stall = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    if (w_haz) begin
                        stall     = 1'b1;
                        ex_bubble = 1'b1;
                    end else if (w_mc_long) begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_ex_v    <= 1'b0;
            r_ex_rd   <= '0;
            r_ex_wen  <= 1'b0;
            r_mem_v   <= 1'b0;
            r_mem_rd  <= '0;
            r_mem_wen <= 1'b0;
`ifdef HAZ_FWD_EN
            r_ex_ld   <= 1'b0;
            r_fwd1    <= 2'b00;
            r_fwd2    <= 2'b00;
`else
            r_wb_v    <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_wen  <= 1'b0;
`endif
        end else if (r_state == ST_BUSY) begin
            // EX and its forward selects hold; a bubble drains into MEM.
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - LAT_W'(1);
            end
            r_mem_v <= 1'b0;
`ifndef HAZ_FWD_EN
            r_wb_v   <= r_mem_v;
            r_wb_rd  <= r_mem_rd;
            r_wb_wen <= r_mem_wen;
`endif
        end else begin
            r_ex_v    <= w_issue;
            r_ex_rd   <= id_rd;
            r_ex_wen  <= id_rd_wen;
            r_mem_v   <= r_ex_v;
            r_mem_rd  <= r_ex_rd;
            r_mem_wen <= r_ex_wen;
            if (w_mc_long) begin
                r_cnt <= id_mc_lat - LAT_W'(2);
            end
`ifdef HAZ_FWD_EN
            r_ex_ld <= id_is_load;
            r_fwd1  <= w_issue ? w_fwd1 : 2'b00;
            r_fwd2  <= w_issue ? w_fwd2 : 2'b00;
`else
            r_wb_v   <= r_mem_v;
            r_wb_rd  <= r_mem_rd;
            r_wb_wen <= r_mem_wen;
`endif
        end
    end

    assign ex_valid = r_ex_v;
    assign busy     = (r_state == ST_BUSY);

`ifndef HAZ_FWD_EN
    // Load flag has no effect without forwarding.
    logic w_unused;
    assign w_unused = id_is_load;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl. The driver applies one ID instruction per
// cycle and queues the outputs expected in that cycle; a negedge monitor pops
// and compares them. Expectations follow the HAZ_FWD_EN setting of the build.
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_wen, id_is_load, id_mc;
    logic [3:0] id_mc_lat;
    logic       stall, ex_bubble, ex_valid, busy;
    logic [1:0] fwd_sel1, fwd_sel2;

    ex_hazard_ctrl #(.REG_ADDR(5), .LAT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_rd      (id_rd),
        .id_rd_wen  (id_rd_wen),
        .id_is_load (id_is_load),
        .id_mc      (id_mc),
        .id_mc_lat  (id_mc_lat),
        .stall      (stall),
        .ex_bubble  (ex_bubble),
        .ex_valid   (ex_valid),
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // {stall, ex_bubble, ex_valid, fwd_sel1, fwd_sel2, busy}
    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_exp, m_got;
    string      m_tag;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_tag = tag_q.pop_front();
            m_got = {stall, ex_bubble, ex_valid, fwd_sel1, fwd_sel2, busy};
            checks++;
            if (m_got !== m_exp) begin
                errors++;
                $display("FAIL %s: got stall=%b bub=%b exv=%b f1=%b f2=%b busy=%b, want stall=%b bub=%b exv=%b f1=%b f2=%b busy=%b",
                         m_tag, m_got[7], m_got[6], m_got[5], m_got[4:3], m_got[2:1], m_got[0],
                         m_exp[7], m_exp[6], m_exp[5], m_exp[4:3], m_exp[2:1], m_exp[0]);
            end
        end
    end

    task automatic ins(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic mc,
                       input logic [3:0] lat);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_rd_wen   = wen;
        id_is_load  = ld;
        id_mc       = mc;
        id_mc_lat   = lat;
    endtask

    task automatic nop();
        ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Queue the outputs expected during the current cycle, then advance.
    task automatic step(input string tag, input logic st, input logic bub,
                        input logic exv, input logic [1:0] f1, input logic [1:0] f2,
                        input logic bsy);
        exp_q.push_back({st, bub, exv, f1, f2, bsy});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        step("reset0", 0, 0, 0, 2'b00, 2'b00, 0);
        step("reset1", 0, 0, 0, 2'b00, 2'b00, 0);
        reset = 1'b0;

`ifdef HAZ_FWD_EN
        ins(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 4'd0);       // add x5
        step("add_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 4'd0);       // sub reads x5
        step("sub_no_stall", 0, 0, 1, 2'b00, 2'b00, 0);
        nop();
        step("sub_fwd_exmem", 0, 0, 1, 2'b01, 2'b00, 0);
        ins(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0, 4'd0);       // add x9
        step("add9_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0, 0, 4'd0);      // independent
        step("indep_issue", 0, 0, 1, 2'b00, 2'b00, 0);
        ins(1, 5'd9, 1, 5'd0, 1, 5'd11, 1, 0, 0, 4'd0);      // reads x9
        step("rd9_issue", 0, 0, 1, 2'b00, 2'b00, 0);
        ins(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 4'd0);       // lw x7
        step("rd9_fwd_memwb", 0, 0, 1, 2'b10, 2'b00, 0);
        ins(1, 5'd3, 1, 5'd7, 1, 5'd12, 1, 0, 0, 4'd0);      // reads x7 via rs2
        step("loaduse_stall", 1, 1, 1, 2'b00, 2'b00, 0);
        step("loaduse_release", 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 4'd0);       // lw x0
        step("loaduse_fwd2", 0, 0, 1, 2'b00, 2'b10, 0);
        ins(1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0, 0, 4'd0);      // reads x0
        step("x0_no_stall", 0, 0, 1, 2'b00, 2'b00, 0);
        nop();
        step("x0_fwd_none", 0, 0, 1, 2'b00, 2'b00, 0);
`else
        ins(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 4'd0);       // add x5
        step("add_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 4'd0);       // reads x5
        step("ilock_ex", 1, 1, 1, 2'b00, 2'b00, 0);
        step("ilock_mem", 1, 1, 0, 2'b00, 2'b00, 0);
        step("ilock_wb", 1, 1, 0, 2'b00, 2'b00, 0);
        step("ilock_release", 0, 0, 0, 2'b00, 2'b00, 0);
        nop();
        step("ilock_issued", 0, 0, 1, 2'b00, 2'b00, 0);
        ins(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 4'd0);       // lw x0
        step("lw0_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0, 0, 4'd0);      // reads x0
        step("x0_no_stall", 0, 0, 1, 2'b00, 2'b00, 0);
        nop();
        step("x0_issued", 0, 0, 1, 2'b00, 2'b00, 0);
`endif

        // Multi-cycle, lat=4: three BUSY stall cycles, four cycles in EX.
        ins(1, 5'd1, 1, 5'd2, 1, 5'd14, 1, 0, 1, 4'd4);
        step("mc4_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 5'd20, 1, 5'd0, 0, 5'd15, 1, 0, 0, 4'd0);
        step("mc4_busy1", 1, 0, 1, 2'b00, 2'b00, 1);
        step("mc4_busy2", 1, 0, 1, 2'b00, 2'b00, 1);
        step("mc4_busy3", 1, 0, 1, 2'b00, 2'b00, 1);
        step("mc4_idle", 0, 0, 1, 2'b00, 2'b00, 0);

        // lat=1 is single-cycle.
        ins(1, 5'd1, 1, 5'd2, 1, 5'd16, 1, 0, 1, 4'd1);
        step("mc1_issue", 0, 0, 1, 2'b00, 2'b00, 0);
        ins(1, 5'd20, 1, 5'd0, 0, 5'd17, 1, 0, 0, 4'd0);
        step("mc1_no_busy", 0, 0, 1, 2'b00, 2'b00, 0);
        nop();
        step("mc1_after", 0, 0, 1, 2'b00, 2'b00, 0);

        // Reset during the second BUSY cycle.
        ins(1, 5'd1, 1, 5'd2, 1, 5'd18, 1, 0, 1, 4'd5);
        step("mc5_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        nop();
        step("mc5_busy1", 1, 0, 1, 2'b00, 2'b00, 1);
        reset = 1'b1;
        step("mc5_busy2_rst", 0, 0, 1, 2'b00, 2'b00, 1);
        reset = 1'b0;
        step("mc5_after_rst", 0, 0, 0, 2'b00, 2'b00, 0);

        for (int unsigned i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
